// File: rtl/truth_table_sweeper.sv
// Sweeps {C,B,A} through indices 0..7, samples the downstream function output Y
// for each index, and grades the captured truth table against EXPECTED.
module truth_table_sweeper #(
   parameter logic [7:0] EXPECTED = 8'h96,
   parameter int         SETTLE   = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       y_in,
   output logic       abc_a,
   output logic       abc_b,
   output logic       abc_c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] table_out,
   output logic [3:0] err_count,
   output logic [2:0] first_err_idx
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_FINISH
   } state_t;

   localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] idx;
   logic [3:0] settle_cnt;
   logic [2:0] abc;
   logic [7:0] tbl_nxt;
   logic       mismatch;

   assign abc_a = abc[0];
   assign abc_b = abc[1];
   assign abc_c = abc[2];

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_SETTLE;
         S_SETTLE: if (settle_cnt == 4'd0) state_nxt = S_SAMPLE;
         S_SAMPLE: state_nxt = (idx == 3'd7) ? S_FINISH : S_SETTLE;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Table including the bit being sampled this cycle; pass is graded on this
   // so the index-7 sample is part of the verdict.
   always_comb begin
      tbl_nxt      = table_out;
      tbl_nxt[idx] = y_in;
      mismatch     = (y_in != EXPECTED[idx]);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idx           <= 3'd0;
         settle_cnt    <= 4'd0;
         abc           <= 3'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         table_out     <= 8'd0;
         err_count     <= 4'd0;
         first_err_idx <= 3'd0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  table_out     <= 8'd0;
                  err_count     <= 4'd0;
                  first_err_idx <= 3'd0;
                  pass          <= 1'b0;
                  idx           <= 3'd0;
                  abc           <= 3'd0;
                  busy          <= 1'b1;
                  settle_cnt    <= CNT_RELOAD;
               end
            end
            S_SETTLE: begin
               if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
            end
            S_SAMPLE: begin
               table_out <= tbl_nxt;
               if (mismatch) begin
                  err_count <= err_count + 4'd1;
                  if (err_count == 4'd0) first_err_idx <= idx;
               end
               if (idx == 3'd7) begin
                  done <= 1'b1;
                  busy <= 1'b0;
                  abc  <= 3'd0;
                  pass <= (tbl_nxt == EXPECTED);
               end else begin
                  idx        <= idx + 3'd1;
                  abc        <= idx + 3'd1;
                  settle_cnt <= CNT_RELOAD;
               end
            end
            S_FINISH: begin
               abc <= 3'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3)
// driven by a behavioural model of the downstream function block.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic [1:0] start_v, y_v, done_v, busy_v, pass_v, a_v, b_v, c_v;
   logic [7:0] tbl_v [2];
   logic [3:0] err_v [2];
   logic [2:0] fe_v  [2];
   logic [7:0] func_tbl;

   typedef struct {
      logic [7:0] tbl;
      logic [3:0] err;
      logic [2:0] fe;
      logic       pass;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      localparam int S = (g == 0) ? 1 : 3;
      logic [2:0] abc;
      assign abc    = {c_v[g], b_v[g], a_v[g]};
      assign y_v[g] = func_tbl[abc];

      truth_table_sweeper #(.EXPECTED(8'h96), .SETTLE(S)) dut (
         .clk          (clk),
         .reset_n      (reset_n),
         .start        (start_v[g]),
         .y_in         (y_v[g]),
         .abc_a        (a_v[g]),
         .abc_b        (b_v[g]),
         .abc_c        (c_v[g]),
         .busy         (busy_v[g]),
         .done         (done_v[g]),
         .pass         (pass_v[g]),
         .table_out    (tbl_v[g]),
         .err_count    (err_v[g]),
         .first_err_idx(fe_v[g])
      );

      int   start_cyc = 0;
      int   last      = 0;
      int   holds[8];
      bit   order_ok  = 1'b1;
      bit   hold_ok;
      logic busy_d    = 1'b0;
      exp_t e;

      always @(negedge clk) begin
         if (busy_v[g] === 1'b1 && busy_d !== 1'b1) begin
            start_cyc = cyc;
            last      = 0;
            order_ok  = 1'b1;
            for (int i = 0; i < 8; i++) holds[i] = 0;
         end
         if (busy_v[g] === 1'b1) begin
            holds[abc]++;
            if (int'(abc) < last) order_ok = 1'b0;
            last = int'(abc);
         end
         if (done_v[g] === 1'b1) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("table_out", 32'(tbl_v[g]), 32'(e.tbl));
               chk("err_count", 32'(err_v[g]), 32'(e.err));
               chk("first_err_idx", 32'(fe_v[g]), 32'(e.fe));
               chk("pass", 32'(pass_v[g]), 32'(e.pass));
               chk("latency", 32'(cyc - start_cyc), 32'(8 * (S + 1)));
               hold_ok = order_ok;
               for (int i = 0; i < 8; i++) if (holds[i] != S + 1) hold_ok = 1'b0;
               chk("abc_hold_order", 32'(hold_ok), 32'd1);
               chk("busy_at_done", 32'(busy_v[g]), 32'd0);
               chk("abc_at_done", 32'(abc), 32'd0);
            end
         end
         busy_d = busy_v[g];
      end
   end

   task automatic pulse(input int g);
      @(negedge clk) start_v[g] = 1'b1;
      @(negedge clk) start_v[g] = 1'b0;
   endtask

   task automatic wait_done(input int g);
      int n = 0;
      while (done_v[g] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (done_v[g] !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_abc(input int g, input logic [2:0] v);
      int n = 0;
      while ({c_v[g], b_v[g], a_v[g]} !== v && n < 200) begin
         @(negedge clk);
         n++;
      end
      if ({c_v[g], b_v[g], a_v[g]} !== v) chk("abc_timeout", 32'd0, 32'd1);
   endtask

   task automatic run(input int g, input logic [7:0] model, input logic [7:0] et,
                      input logic [3:0] ee, input logic [2:0] ef, input logic ep);
      func_tbl = model;
      sb.push_back('{tbl: et, err: ee, fe: ef, pass: ep});
      pulse(g);
      wait_done(g);
      @(negedge clk);
   endtask

   task automatic chk_zero(input int g, input string tag);
      chk({tag, "_busy"},  32'(busy_v[g]), 32'd0);
      chk({tag, "_done"},  32'(done_v[g]), 32'd0);
      chk({tag, "_pass"},  32'(pass_v[g]), 32'd0);
      chk({tag, "_table"}, 32'(tbl_v[g]),  32'd0);
      chk({tag, "_err"},   32'(err_v[g]),  32'd0);
      chk({tag, "_fe"},    32'(fe_v[g]),   32'd0);
      chk({tag, "_abc"},   32'({c_v[g], b_v[g], a_v[g]}), 32'd0);
   endtask

   initial begin
      reset_n  = 1'b0;
      start_v  = 2'b00;
      func_tbl = 8'h96;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk_zero(0, "rst0");
      chk_zero(1, "rst1");

      // function 1, function 2, Y stuck high, then extra boundary tables
      run(0, 8'h96, 8'h96, 4'd0, 3'd0, 1'b1);
      run(0, 8'h73, 8'h73, 4'd5, 3'd0, 1'b0);
      run(0, 8'hFF, 8'hFF, 4'd4, 3'd0, 1'b0);
      run(0, 8'h94, 8'h94, 4'd1, 3'd1, 1'b0);
      run(0, 8'h00, 8'h00, 4'd4, 3'd1, 1'b0);
      run(0, 8'h69, 8'h69, 4'd8, 3'd0, 1'b0);
      run(0, 8'h16, 8'h16, 4'd1, 3'd7, 1'b0);

      // start mid-sweep is ignored; then start held high re-triggers after FINISH
      func_tbl = 8'h96;
      sb.push_back('{tbl: 8'h96, err: 4'd0, fe: 3'd0, pass: 1'b1});
      sb.push_back('{tbl: 8'h96, err: 4'd0, fe: 3'd0, pass: 1'b1});
      pulse(0);
      wait_abc(0, 3'd3);
      pulse(0);
      start_v[0] = 1'b1;
      wait_done(0);
      @(negedge clk);
      chk("idle_gap_busy", 32'(busy_v[0]), 32'd0);
      chk("idle_gap_done", 32'(done_v[0]), 32'd0);
      @(negedge clk);
      chk("retrigger_busy", 32'(busy_v[0]), 32'd1);
      chk("retrigger_table_clear", 32'(tbl_v[0]), 32'd0);
      chk("retrigger_pass_clear", 32'(pass_v[0]), 32'd0);
      start_v[0] = 1'b0;
      wait_done(0);
      @(negedge clk);

      // reset mid-sweep after three samples
      func_tbl = 8'h96;
      pulse(0);
      wait_abc(0, 3'd3);
      chk("pre_reset_table", 32'(tbl_v[0]), 32'h06);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk_zero(0, "midrst");
      repeat (20) @(negedge clk);
      run(0, 8'h96, 8'h96, 4'd0, 3'd0, 1'b1);

      // SETTLE = 3 instance
      run(1, 8'h96, 8'h96, 4'd0, 3'd0, 1'b1);
      run(1, 8'h73, 8'h73, 4'd5, 3'd0, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage that sits directly upstream of the 3-input mux-based function blocks (8:1, 4:1 and 2:1 implementations).
- Drives A, B and C through all 8 combinations (index = {C,B,A}), waits a settle interval, and samples the function output Y for each index.
- Builds an 8-bit truth table, compares it against an expected constant, and reports pass/fail plus error statistics.
- Lets each mux implementation be self-checked in hardware from a single start pulse.

Parameters:
EXPECTED, 8'h96, expected truth table; bit i = Y for index i = {C,B,A} (8'h96 = function 1, 8'h73 = function 2)
SETTLE, 1, cycles the driven inputs are held before the sample cycle; legal range 1..15

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
start  input  1  sweep request; sampled only in IDLE
y_in  input  1  function output Y from the downstream mux block, same clock domain
abc_a  output  1  drives A (index bit 0)
abc_b  output  1  drives B (index bit 1)
abc_c  output  1  drives C (index bit 2)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the sweep completes
pass  output  1  table_out == EXPECTED; valid from done until the next accepted start
table_out  output  8  captured truth table
err_count  output  4  number of mismatching indices, 0..8
first_err_idx  output  3  lowest mismatching index; 0 when err_count == 0

Behaviour:
- Reset: one clock, synchronous, active-low (reset_n sampled low on a clk rising edge).
- All state and outputs are registered. On reset, every output is 0 and the FSM enters IDLE. This applies mid-sweep too: partial results are discarded and no done pulse is issued.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - abc = 000, busy = 0.
  - On start = 1: clear table_out, err_count and first_err_idx; clear pass. Set idx = 0, busy = 1, settle counter = SETTLE - 1. Go to SETTLE.
- SETTLE:
  - {abc_c, abc_b, abc_a} = idx.
  - Counter decrements each cycle; when the counter == 0, go to SAMPLE.
  - SETTLE lasts exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - abc still = idx.
  - table_out[idx] <= y_in.
  - If y_in != EXPECTED[idx]: err_count += 1, and first_err_idx <= idx if this is the first error of the sweep.
  - If idx == 7, go to FINISH. Otherwise idx += 1, reload the counter, go to SETTLE.
  - The new abc value appears the cycle after SAMPLE.
- Index order: each index is held for exactly SETTLE+1 cycles, in the order 0,1,...,7. There is no wrap within a sweep.
- FINISH (1 cycle):
  - done = 1, busy = 0, abc = 000.
  - pass <= (final table == EXPECTED); compute it from the completed table including the idx-7 sample.
  - Go to IDLE.
- Latency: start is accepted at edge 0 and done is high during cycle 8*(SETTLE+1)+1 after acceptance. That is 17 cycles for SETTLE = 1 and 33 for SETTLE = 3.
- start while busy or in FINISH is ignored; there is no queuing.
  - start held high continuously re-triggers on the first IDLE cycle after FINISH. Back-to-back sweeps therefore have one idle cycle between them.
- Results (table_out, err_count, first_err_idx, pass) hold their values after done until the next accepted start or reset.
- err_count width 4 holds 8 without overflow.
- y_in is treated as synchronous to clk; no synchronizer.

Test Plan:
1. Reset, EXPECTED = 8'h96, y_in from a model of function 1 (0x96), SETTLE = 1, pulse start. Required:
   - abc steps 000..111, each held 2 cycles.
   - done 17 cycles after acceptance.
   - table_out = 8'h96, pass = 1, err_count = 0, first_err_idx = 0.
2. Same EXPECTED, y_in from a model of function 2 (0x73). Required: table_out = 8'h73, pass = 0, err_count = 5 (XOR = 0xE5), first_err_idx = 0.
3. y_in tied to 1. Required: table_out = 8'hFF, err_count = 4 (XOR = 0x69), first_err_idx = 0, pass = 0.
4. Pulse start again at idx 3 mid-sweep. Required: ignored, sweep finishes at the original cycle. Then hold start high. Required: new sweep begins 1 cycle after FINISH, table_out cleared to 0 on acceptance.
5. Assert reset_n = 0 for one cycle after 3 vectors are sampled. Required: next cycle all outputs 0, IDLE, no done. A following start produces a full correct sweep.
6. SETTLE = 3 with the function-1 model. Required: each abc value held 4 cycles, done 33 cycles after acceptance, pass = 1.
